// File: rtl/timer_pkg.sv
// Shared definitions for the tick timer: state encoding and default counter width.
package timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle between a sequencing FSM (master) and the tick timer (slave).
interface tick_timer_if
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             tick_in;
  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;
  logic             expired;

  modport master (
    output tick_in, start, pause, clear, limit,
    input  count, running, done, expired
  );

  modport slave (
    input  tick_in, start, pause, clear, limit,
    output count, running, done, expired
  );

endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector for a level already synchronous to clock (e.g. clockDiv).
module edge_rise (
  input  logic clock,
  input  logic rst,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/tick_timer.sv
// Interval timer counting rising edges of the divided clock up to a latched limit,
// with pause/resume, clear and a completion pulse.
module tick_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic         clock,
  input  logic         rst,
  tick_timer_if.slave  bus
);

  localparam int unsigned CW = WIDTH + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             tick_rise;
  logic [CW-1:0]    count_inc;
  logic             last_tick;

  edge_rise u_edge_rise (
    .clock  (clock),
    .rst    (rst),
    .level  (bus.tick_in),
    .rise_c (tick_rise)
  );

  // Extra bit keeps limit = 2^WIDTH-1 from wrapping in the compare.
  assign count_inc = CW'(count_q) + CW'(1);
  assign last_tick = (count_inc == CW'(limit_q));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      limit_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      limit_q   <= limit_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  // Priority: clear > start > pause > tick_rise.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    done_d  = 1'b0;

    if (bus.clear) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (bus.start) begin
      limit_d = bus.limit;
      count_d = '0;
      if (bus.limit == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (tick_rise) begin
            if (last_tick) begin
              count_d = limit_q;
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              count_d = count_inc[WIDTH-1:0];
            end
          end
        end
        S_PAUSE: begin
          if (bus.pause) state_d = S_RUN;
        end
        default: ;
      endcase
    end

    running_d = (state_d == S_RUN);
    expired_d = (state_d == S_DONE);
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: cycle vector table through a scoreboard,
// plus hand sequences for full-width count and mid-run reset.
module tb_tick_timer;

  logic clock;
  logic rst;

  tick_timer_if #(.WIDTH(16)) bus ();
  tick_timer_if #(.WIDTH(4))  bus4 ();

  tick_timer #(.WIDTH(16)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  tick_timer #(.WIDTH(4)) dut4 (
    .clock (clock),
    .rst   (rst),
    .bus   (bus4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic        pause;
    logic        clear;
    logic        tick;
    logic [15:0] limit;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        expired;
  } vec_t;

  typedef struct {
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        expired;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic s, input logic p, input logic c, input logic t,
                     input logic [15:0] lim, input logic [15:0] cnt,
                     input logic run, input logic dn, input logic ex);
    vec_t v;
    v.start = s; v.pause = p; v.clear = c; v.tick = t; v.limit = lim;
    v.count = cnt; v.running = run; v.done = dn; v.expired = ex;
    vecs.push_back(v);
  endtask

  task automatic hold(input int n, input logic t, input logic [15:0] cnt,
                      input logic run, input logic dn, input logic ex);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, t, 16'd0, cnt, run, dn, ex);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.tick_in = 1'b0; bus.limit = '0;
    bus4.start = 1'b0; bus4.pause = 1'b0; bus4.clear = 1'b0; bus4.tick_in = 1'b0; bus4.limit = '0;
  endtask

  task automatic build_table();
    // limit 3, tick rising every 10 cycles
    add(1, 0, 0, 0, 16'd3, 16'd0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      hold(5, 1'b0, 16'(k - 1), 1'b1, 1'b0, 1'b0);
      if (k < 3) begin
        add(0, 0, 0, 1, 16'd0, 16'(k), 1, 0, 0);
        hold(4, 1'b1, 16'(k), 1'b1, 1'b0, 1'b0);
      end else begin
        add(0, 0, 0, 1, 16'd0, 16'd3, 0, 1, 1);
        hold(4, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1);
      end
    end
    add(0, 1, 0, 0, 16'd0, 16'd3, 0, 0, 1);   // pause ignored in DONE
    add(0, 0, 0, 1, 16'd0, 16'd3, 0, 0, 1);   // tick ignored in DONE

    // limit 5, pause after 2 ticks, 4 ticks while paused
    add(1, 0, 0, 0, 16'd5, 16'd0, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd1, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd1, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd2, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd2, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 16'd2, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 0, 1, 16'd0, 16'd2, 0, 0, 0);
      add(0, 0, 0, 0, 16'd0, 16'd2, 0, 0, 0);
    end
    add(0, 1, 0, 1, 16'd0, 16'd2, 1, 0, 0);   // edge in resume cycle not counted
    add(0, 0, 0, 0, 16'd0, 16'd2, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd3, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd3, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd4, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd4, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd5, 0, 1, 1);
    add(0, 0, 0, 0, 16'd0, 16'd5, 0, 0, 1);

    // limit 0 finishes immediately, also when restarted from DONE
    add(1, 0, 0, 0, 16'd0, 16'd0, 0, 1, 1);
    add(0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 1);
    add(1, 0, 0, 0, 16'd0, 16'd0, 0, 1, 1);
    add(0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 1);

    // restart at count 4 with a simultaneous tick
    add(1, 0, 0, 0, 16'd6, 16'd0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(0, 0, 0, 1, 16'd0, 16'(k), 1, 0, 0);
      add(0, 0, 0, 0, 16'd0, 16'(k), 1, 0, 0);
    end
    add(1, 0, 0, 1, 16'd2, 16'd0, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd0, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd1, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd1, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd2, 0, 1, 1);
    add(0, 0, 0, 0, 16'd0, 16'd2, 0, 0, 1);
    add(0, 0, 1, 0, 16'd0, 16'd0, 0, 0, 0);   // clear from DONE

    // clear beats start at count 4
    add(1, 0, 0, 0, 16'd6, 16'd0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(0, 0, 0, 1, 16'd0, 16'(k), 1, 0, 0);
      add(0, 0, 0, 0, 16'd0, 16'(k), 1, 0, 0);
    end
    add(1, 0, 1, 0, 16'd9, 16'd0, 0, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd0, 0, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 0);

    // start accepted while paused
    add(1, 0, 0, 0, 16'd3, 16'd0, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd1, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd1, 1, 0, 0);
    add(0, 1, 0, 0, 16'd0, 16'd1, 0, 0, 0);
    add(1, 0, 0, 0, 16'd2, 16'd0, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd1, 1, 0, 0);
    add(0, 0, 0, 0, 16'd0, 16'd1, 1, 0, 0);
    add(0, 0, 0, 1, 16'd0, 16'd2, 0, 1, 1);
  endtask

  initial begin
    exp_t e;
    int   done_cnt;

    idle_inputs();
    rst = 1'b1;
    step();
    check("rst_hold count", bus.count, 16'd0);
    check("rst_hold running", 16'(bus.running), 16'd0);
    step();
    rst = 1'b0;
    step();
    check("reset count", bus.count, 16'd0);
    check("reset running", 16'(bus.running), 16'd0);
    check("reset done", 16'(bus.done), 16'd0);
    check("reset expired", 16'(bus.expired), 16'd0);

    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      bus.start   = vecs[i].start;
      bus.pause   = vecs[i].pause;
      bus.clear   = vecs[i].clear;
      bus.tick_in = vecs[i].tick;
      bus.limit   = vecs[i].limit;
      e.count   = vecs[i].count;
      e.running = vecs[i].running;
      e.done    = vecs[i].done;
      e.expired = vecs[i].expired;
      e.idx     = i;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      check($sformatf("v%0d count", e.idx), bus.count, e.count);
      check($sformatf("v%0d running", e.idx), 16'(bus.running), 16'(e.running));
      check($sformatf("v%0d done", e.idx), 16'(bus.done), 16'(e.done));
      check($sformatf("v%0d expired", e.idx), 16'(bus.expired), 16'(e.expired));
    end
    idle_inputs();
    step();

    // 4-bit instance counts to 15 without wrapping
    bus4.start = 1'b1;
    bus4.limit = 4'd15;
    step();
    bus4.start = 1'b0;
    check("w4 start count", 16'(bus4.count), 16'd0);
    check("w4 start running", 16'(bus4.running), 16'd1);
    done_cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      bus4.tick_in = 1'b1;
      step();
      check($sformatf("w4 count%0d", k), 16'(bus4.count), 16'(k));
      if (bus4.done) done_cnt++;
      bus4.tick_in = 1'b0;
      step();
      if (bus4.done) done_cnt++;
    end
    check("w4 done pulses", 16'(done_cnt), 16'd1);
    check("w4 expired", 16'(bus4.expired), 16'd1);
    bus4.tick_in = 1'b1;
    step();
    check("w4 no wrap", 16'(bus4.count), 16'd15);
    bus4.tick_in = 1'b0;

    // reset mid-run with tick_in held high through release
    bus.start = 1'b1;
    bus.limit = 16'd20;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.tick_in = 1'b0;
      step();
      bus.tick_in = 1'b1;
      step();
    end
    check("pre_rst count", bus.count, 16'd7);
    check("pre_rst running", 16'(bus.running), 16'd1);
    #3 rst = 1'b1;
    #1;
    check("async rst count", bus.count, 16'd0);
    check("async rst running", 16'(bus.running), 16'd0);
    check("async rst expired", 16'(bus.expired), 16'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    check("post_rst count", bus.count, 16'd0);
    check("post_rst running", 16'(bus.running), 16'd0);
    bus.tick_in = 1'b0;
    step();
    bus.tick_in = 1'b1;
    step();
    check("idle tick count", bus.count, 16'd0);
    check("idle tick running", 16'(bus.running), 16'd0);
    bus.start = 1'b1;
    bus.limit = 16'd2;
    step();
    bus.start = 1'b0;
    check("restart count", bus.count, 16'd0);
    check("restart running", 16'(bus.running), 16'd1);
    step();
    check("held high count", bus.count, 16'd0);
    bus.tick_in = 1'b0;
    step();
    bus.tick_in = 1'b1;
    step();
    check("fresh edge count", bus.count, 16'd1);
    bus.tick_in = 1'b0;
    step();
    bus.tick_in = 1'b1;
    step();
    check("final count", bus.count, 16'd2);
    check("final done", 16'(bus.done), 16'd1);
    check("final expired", 16'(bus.expired), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
# tick_timer

Programmable interval timer that consumes the divided clock signal `clockDiv` produced by the clock divider. It runs entirely in the `clock` domain and treats `clockDiv` as data, never as a clock. Each rising edge of `clockDiv` counts as one tick. It counts ticks up to a limit latched at start, supports pause/resume and clear, and reports completion. Game and sequencing FSMs downstream use it for timeouts and delays.

## Interface
- `WIDTH`, default 16: width of `limit` and `count`.
- `clock`  in  1: system clock, the same clock that drives the divider.
- `rst`  in  1: reset, asynchronous, active-high.
- `tick_in`  in  1: the divider's `clockDiv` output. It is synchronous to `clock`, so no synchronizer is used.
- `start`  in  1: one-cycle pulse. Latches `limit`, zeroes `count` and starts counting.
- `pause`  in  1: one-cycle pulse. Toggles between RUN and PAUSE.
- `clear`  in  1: one-cycle pulse. Aborts the timer and returns it to IDLE.
- `limit`  in  WIDTH: number of ticks to count. Sampled only when `start` is accepted.
- `count`  out  WIDTH: ticks elapsed since the last start.
- `running`  out  1: high in RUN only.
- `done`  out  1: one-cycle pulse on entry to DONE.
- `expired`  out  1: level, high while in DONE.

## Operation
- Edge detection:
  - `tick_q` registers `tick_in`.
  - `tick_rise = tick_in & ~tick_q`, which is combinational and one cycle wide.
  - Falling edges are ignored.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority per cycle: `clear` > `start` > `pause` > `tick_rise`.
- `clear` in any state: go to IDLE, `count`←0, `limit_q` is kept.
- `start` in any state, including RUN, PAUSE and DONE:
  - `limit_q`←`limit`, `count`←0.
  - If `limit`==0, go to DONE with the `done` pulse. Otherwise go to RUN.
  - A `tick_rise` in the same cycle is dropped.
- RUN, on `tick_rise`:
  - If `count+1 == limit_q`: `count`←`limit_q`, go to DONE.
  - Otherwise `count`←`count+1`.
- RUN, on `pause`: go to PAUSE, `count` holds.
- PAUSE:
  - `tick_rise` is ignored.
  - `pause` returns to RUN.
  - A tick edge that arrives in the cycle of resume is not counted.
- IDLE, DONE: `pause` and `tick_rise` are ignored.
- DONE: `count` holds `limit_q`. The block stays in DONE until `start` or `clear`.
- Width rules:
  - `count` never exceeds `limit_q`.
  - The `count+1` compare is done at WIDTH+1 bits, so `limit`=2^WIDTH−1 completes without wrap.
- `rst` mid-operation: all state is lost immediately, which is the same as the reset values below.

## Timing
- Reset values: state=IDLE, `count`=0, `limit_q`=0, `tick_q`=0, `running`=0, `done`=0, `expired`=0.
- All outputs are registered.
- `start` accepted at edge N: `running`=1 and `count`=0 from cycle N+1.
- `tick_in` rises in cycle T, with `tick_q` low: `count` increments visibly at T+1.
- Final tick in cycle T: at T+1, `done`=1 for exactly one cycle, `expired`=1, `running`=0.
- `start` with `limit`=0 at edge N: `done`=1 and `expired`=1 at N+1.
- With the divider configured as specified (half-period 500 cycles), ticks are 1000 `clock` cycles apart. The block must still work for ticks as close as every 2 cycles.

## Structure
- Shared package `timer_pkg`: state encoding localparams (`S_IDLE`=2'd0, `S_RUN`=2'd1, `S_PAUSE`=2'd2, `S_DONE`=2'd3) and the default `WIDTH`.
- One sub-module, `edge_rise`: the `tick_q` register plus the rise pulse, async reset to 0. It is reused by other consumers of `clockDiv`.
- Top level: FSM, `count`/`limit_q` datapath, and registered output decode.

## Test plan
- Reset, then `start` with `limit`=3 and a tick every 10 cycles:
  - `count` goes 0→1→2→3.
  - `done` pulses one cycle after the 3rd `tick_in` rise.
  - `expired` then stays 1 and `running`=0.
- `limit`=5, `pause` after 2 ticks:
  - 4 ticks arrive during PAUSE, then `pause` again.
  - `count` holds at 2 during PAUSE.
  - `done` is asserted after 3 further ticks.
- `start` with `limit`=0: `done`=1 and `expired`=1 the next cycle, `count`=0.
- In RUN with `count`=4:
  - `start` with `limit`=2 and a simultaneous tick: `count`=0, the tick is dropped, then done after 2 ticks.
  - `clear` together with `start`: the result is IDLE with `count`=0.
- WIDTH=4, `limit`=15: count reaches 15 without wrap, and `done` pulses once.
- Assert `rst` in RUN with `count`=7, with `tick_in` held high through release:
  - All outputs reset immediately.
  - No tick is counted after release until a new `start` and a fresh rising edge.
